// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared types, size codes and byte-enable helpers for riscv_mem_responder.
package riscv_mem_pkg;
  typedef enum logic {MEM_CLEAR, MEM_READY} mem_state_e;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  function automatic logic [3:0] exp_be(input logic [1:0] size, input logic [1:0] a);
    return size == SZ_B ? 4'b0001 << a :
           size == SZ_H ? (a[1] ? 4'b1100 : 4'b0011) :
           size == SZ_W ? 4'b1111 : 4'b0000;
  endfunction
  // 33-bit compare so BASE_ADDR + 4*DEPTH_WORDS may reach 2^32 without wrapping
  function automatic logic mem_in_range(input logic [31:0] addr, input logic [31:0] base,
                                        input logic [32:0] lim);
    return addr >= base && {1'b0, addr - base} < lim;
  endfunction
endpackage

// File: rtl/riscv_mem_access_check.sv
// riscv_mem_access_check: combinational range, size, alignment and byte-enable legality of a data access.
module riscv_mem_access_check
  import riscv_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic [3:0]  be,
  output logic        in_range,
  output logic        legal
);
  localparam logic [32:0] LIM = 33'(DEPTH_WORDS) << 2;
  logic aligned;
  assign in_range = mem_in_range(addr, BASE_ADDR, LIM);
  assign aligned  = size == SZ_H ? !addr[0] : size == SZ_W ? addr[1:0] == 2'b00 : 1'b1;
  assign legal    = in_range && size != 2'd3 && aligned && be == exp_be(size, addr[1:0]);
endmodule

// File: rtl/riscv_mem_responder.sv
// riscv_mem_responder: single-port-per-side memory for the RV32 core with 1-cycle reads, byte stores,
// sticky error capture and traffic counters; MEM_CLEAR_EN adds a zeroing sequence after reset.
module riscv_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        ird_i,
  input  logic [31:0] iaddr_i,
  output logic [31:0] irdata_o,
  input  logic        drd_i,
  input  logic        dwr_i,
  input  logic [31:0] daddr_i,
  input  logic [31:0] dwdata_i,
  input  logic [1:0]  dsize_i,
  input  logic [3:0]  dbe_i,
  output logic [31:0] drdata_o,
  output logic        busy_o,
  output logic        err_o,
  output logic [31:0] err_addr_o,
  output logic [31:0] rd_cnt_o,
  output logic [31:0] wr_cnt_o
);
  localparam int          AW  = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIM = 33'(DEPTH_WORDS) << 2;
  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] iidx, didx, wr_idx;
  logic [31:0]   wr_data;
  logic [3:0]    wr_be;
  logic          i_in, d_in, d_legal, d_err, i_err, clr;
  assign iidx = AW'((iaddr_i - BASE_ADDR) >> 2);
  assign didx = AW'((daddr_i - BASE_ADDR) >> 2);
  assign i_in = mem_in_range(iaddr_i, BASE_ADDR, LIM);
  riscv_mem_access_check #(.DEPTH_WORDS(DEPTH_WORDS), .BASE_ADDR(BASE_ADDR)) u_dchk (
    .addr(daddr_i), .size(dsize_i), .be(dbe_i), .in_range(d_in), .legal(d_legal)
  );
  assign d_err = (drd_i || dwr_i) && !(d_in && d_legal);
  assign i_err = ird_i && !i_in;
`ifdef MEM_CLEAR_EN
  mem_state_e    state;
  logic [AW-1:0] ptr;
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      state <= MEM_CLEAR;
      ptr   <= '0;
    end else if (state == MEM_CLEAR) begin
      ptr <= ptr + 1'b1;
      if (ptr == AW'(DEPTH_WORDS - 1)) state <= MEM_READY;
    end
  assign clr     = state == MEM_CLEAR;
  assign wr_idx  = clr ? ptr : didx;
`else
  assign clr     = 1'b0;
  assign wr_idx  = didx;
`endif
  assign busy_o  = clr;
  assign wr_data = clr ? '0 : dwdata_i;
  assign wr_be   = clr ? 4'b1111 : (dwr_i && d_legal) ? dbe_i : 4'b0000;
  always_ff @(posedge clk_i)
    for (int k = 0; k < 4; k++)
      if (wr_be[k]) mem[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
  // Reads sample mem before this edge's store lands, giving read-before-write on both ports
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      irdata_o   <= '0;
      drdata_o   <= '0;
      err_o      <= 1'b0;
      err_addr_o <= '0;
      rd_cnt_o   <= '0;
      wr_cnt_o   <= '0;
    end else if (clr) begin
      irdata_o <= '0;
      drdata_o <= '0;
    end else begin
      if (ird_i) irdata_o <= i_in ? mem[iidx] : NOP_INSN;
      if (drd_i) drdata_o <= d_legal ? mem[didx] : '0;
      if (drd_i && d_legal && rd_cnt_o != '1) rd_cnt_o <= rd_cnt_o + 1'b1;
      if (dwr_i && d_legal && wr_cnt_o != '1) wr_cnt_o <= wr_cnt_o + 1'b1;
      if (!err_o && (d_err || i_err)) begin
        err_o      <= 1'b1;
        err_addr_o <= d_err ? daddr_i : iaddr_i;
      end
    end
endmodule

// File: doc/riscv_mem_responder.md
# riscv_mem_responder

Memory-side responder for the pipelined RV32 core's instruction and data memory ports. It answers instruction fetches and data loads with one-cycle registered read data and performs byte-enabled stores. It flags illegal accesses and counts traffic for the formal and simulation benches. It sits beside `top` in the bind/test harness and replaces ad-hoc memory models as the single memory the core talks to.

## Interface
- `DEPTH_WORDS`, default 1024, number of 32-bit words; power of two, at least 4.
- `BASE_ADDR`, default 32'h0000_0000, byte address of word 0; 4-byte aligned.
- `clk_i` in 1: single clock; all state is updated on the rising edge.
- `reset_i` in 1: asynchronous, active-low reset.
- `ird_i` in 1: instruction fetch request.
- `iaddr_i` in 32: fetch byte address.
- `irdata_o` out 32: fetched instruction, registered.
- `drd_i` in 1: data load request.
- `dwr_i` in 1: data store request.
- `daddr_i` in 32: data byte address.
- `dwdata_i` in 32: store data, already lane-aligned by the core.
- `dsize_i` in 2: access size; 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `dbe_i` in 4: byte lane enables.
- `drdata_o` out 32: full aligned word for loads, registered; the core extracts lanes and sign-extends.
- `busy_o` out 1: clear sequence in progress.
- `err_o` out 1: sticky access error.
- `err_addr_o` out 32: byte address of the first error.
- `rd_cnt_o` out 32: count of accepted data loads.
- `wr_cnt_o` out 32: count of accepted data stores.

## Operation
- Word index = (addr − `BASE_ADDR`)[log2(`DEPTH_WORDS`)+1:2].
- An address is in range iff `BASE_ADDR` ≤ addr < `BASE_ADDR` + 4·`DEPTH_WORDS`.
- Fetch:
  - In-range `ird_i`: `irdata_o` ← mem[index].
  - Out-of-range: `irdata_o` ← 32'h0000_0013 (NOP) and an error is raised.
  - No `ird_i`: `irdata_o` holds its value.
- Load, `drd_i`:
  - Legal access: `drdata_o` ← mem[index] and `rd_cnt_o` increments.
  - Illegal access: `drdata_o` ← 0 and an error is raised.
  - No `drd_i`: `drdata_o` holds its value.
- Store, `dwr_i`: when legal, each lane k with `dbe_i[k]` set takes `dwdata_i[8k+7:8k]`, and `wr_cnt_o` increments. When illegal, nothing is written.
- A data access is legal only if all of these hold:
  - the address is in range;
  - `dsize_i` ≠ 3;
  - alignment matches size: half needs addr[0] = 0, word needs addr[1:0] = 0;
  - `dbe_i` matches size: byte is one-hot at lane addr[1:0], half is 4'b0011 or 4'b1100 selected by addr[1], word is 4'b1111.
- Load and store to the same word in the same cycle: the load returns pre-store data (read-before-write).
- A fetch and a store to the same word in the same cycle: the fetch also returns old data.
- Errors:
  - The first error sets `err_o` and captures its address in `err_addr_o`; later errors leave both unchanged.
  - `err_o` clears only on reset.
  - If fetch and data errors occur in the same cycle, the data address is captured.
- Both counters saturate at 32'hFFFF_FFFF.
- FSM states are CLEAR and READY.
  - CLEAR: a pointer writes 0 to words 0 … `DEPTH_WORDS`−1, one per cycle, and `busy_o` = 1. All requests are ignored: no writes, no counter changes, no errors, and read outputs are forced to 0.
  - After the last word is written, the FSM moves to READY.
  - READY is terminal until reset.

## Timing
- Read latency is 1: data requested in cycle n is valid after edge n+1. There is no stall or ready signal, and a request is accepted every cycle.
- Stores commit on the edge that samples the request.
- Reset values:
  - `irdata_o` = 0, `drdata_o` = 0.
  - `busy_o` = 1 with the macro enabled, else 0.
  - `err_o` = 0, `err_addr_o` = 0.
  - Both counters = 0.
  - FSM = CLEAR with the macro enabled, else READY; clear pointer = 0.
- Reset asserted mid-clear restarts the clear from word 0 after release. Memory contents themselves are not reset asynchronously.
- With the macro enabled, the clear takes exactly `DEPTH_WORDS` cycles after reset release.

## Configuration
- `MEM_CLEAR_EN`:
  - Defined: the CLEAR sequence runs after every reset as described above.
  - Undefined: there is no clear FSM or pointer, the block resets directly into READY, `busy_o` is tied to 0, and memory contents are unspecified until written (benches preload them).

## Structure
- Package `riscv_mem_pkg` holds:
  - the state enum `mem_state_e` (MEM_CLEAR, MEM_READY);
  - the size constants SZ_B, SZ_H, SZ_W;
  - `NOP_INSN` = 32'h0000_0013;
  - the function computing the expected byte enables from size and addr[1:0].
- Sub-module `riscv_mem_access_check` is purely combinational. It takes addr, size, be and the parameters, and returns `in_range` and `legal`. It is instantiated once for the data port; the fetch port uses only its range logic.

## Test plan
- Clear (macro defined), `DEPTH_WORDS` = 16: reset release -> `busy_o` = 1 for exactly 16 cycles; after that, a load of 0x8 returns 0.
- Word store 0xCAFEBABE to 0x10 with be 4'b1111, then a byte store 0x55 to 0x11 with be 4'b0010 -> a load of 0x10 returns 0xCAFE55BE one cycle later; `wr_cnt_o` = 2 and `rd_cnt_o` = 1.
- Store 0x11111111 and load in the same cycle to word 0x4 (old 0x0) -> `drdata_o` = 0x0; the next load returns 0x11111111.
- Misaligned word load at 0x6 -> `drdata_o` = 0, `err_o` = 1, `err_addr_o` = 0x6. A later out-of-range store to 0x1000 -> `err_addr_o` stays 0x6 and memory is unchanged.
- Fetch at 0x1000 with `DEPTH_WORDS` = 1024 -> `irdata_o` = 0x00000013 and `err_o` = 1.
- Reset asserted at clear cycle 5 -> all outputs return to reset values immediately; after release, `busy_o` lasts the full `DEPTH_WORDS` cycles.
